ps2_rx: RTL and testbench
=========================

// Module: ps2_rx
// PURPOSE
//  PS/2 keyboard receiver; upstream of the system top, fed by the board kbd pair {PS2_DAT, PS2_CLK}.
//  Synchronises and deglitches the lines, deframes 11-bit PS/2 frames, checks parity, stop bit and timeout.
//  Buffers scan codes in a FIFO and presents them on a valid/ready interface to the consumer.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency, Hz
//  FILTER_LEN  8           consecutive equal samples needed before filtered ps2_clk changes (>=2)
//  TIMEOUT_US  200         max gap between falling edges inside a frame, us
//  FIFO_DEPTH  4           scan-code FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  ps2_clk     in   1  raw PS/2 clock line, async, idle high
//  ps2_dat     in   1  raw PS/2 data line, async, idle high
//  code        out  8  scan code at FIFO head
//  ext         out  1  head entry preceded by E0 (macro only, else 0)
//  brk         out  1  head entry preceded by F0 (macro only, else 0)
//  valid       out  1  FIFO not empty
//  ready       in   1  consumer accepts head; pop on valid&&ready
//  err_parity  out  1  1-cycle pulse: parity failure, frame discarded
//  err_frame   out  1  1-cycle pulse: bad start/stop bit or timeout, frame discarded
//  overflow    out  1  1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, filtered clk = 1, pending flags 0, counters 0.
//   Async assert, sync deassert through the 2-FF sync chain; reset mid-frame discards the partial frame.
//  Input path: 2-FF sync on both lines.
//   Filtered clk toggles only after FILTER_LEN equal synced samples.
//   Falling edge of filtered clk -> 1-cycle strobe, samples synced dat.
//   Pin-to-strobe latency: 2 + FILTER_LEN cycles.
//  FSM (advances only on strobe, except timeout):
//   IDLE:   dat=0 -> DATA, bitcnt=0; dat=1 -> stay, err_frame pulse.
//   DATA:   shift in LSB first; after 8th bit -> PARITY.
//   PARITY: latch bit -> STOP.
//   STOP:   dat=1 and odd parity over 9 bits -> good byte; dat=1 and parity bad -> err_parity; dat=0 -> err_frame; always -> IDLE.
//   Timeout: in any non-IDLE state, a cycle counter cleared on every strobe reaches CLK_HZ/1_000_000*TIMEOUT_US.
//    Result: -> IDLE, err_frame pulse, partial frame discarded.
//  FIFO: first-word fall-through; code/ext/brk reflect head whenever valid=1 and are held stable while ready=0.
//   Good byte on STOP strobe in cycle N -> written end of N; if FIFO was empty, valid=1 in N+1.
//   Full and push with no pop: byte dropped, overflow pulse, contents unchanged.
//   Full and push with simultaneous pop: both happen, count unchanged.
//   Empty and ready=1: no effect.
//   Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  Error pulses are mutually exclusive per frame and never coincide with a push.
// CONFIGURATION
//  PS2_PREFIX_DECODE_EN defined:
//   Good byte E0 sets ext_pend, F0 sets brk_pend; neither is pushed.
//   Next other good byte is pushed with {ext,brk}={ext_pend,brk_pend}, then both pendings clear.
//   Any err_parity/err_frame also clears pendings.
//  Not defined: every good byte (including E0/F0) is pushed raw; ext=brk=0 constantly.
// TESTING (bench may set CLK_HZ=1_000_000, PS2 bit period 40 clk)
//  1. Frame 0x1C, parity 0, stop 1, ready=0 -> valid=1, code=0x1C, ext=brk=0, held 20 cycles.
//     ready=1 -> valid=0 next cycle.
//  2. Bytes E0,F0,74 -> macro on: one entry 0x74, ext=1, brk=1.
//     Macro off: three entries E0,F0,74 in order, ext=brk=0.
//  3. Frame 0x1C with parity bit 1 -> err_parity single pulse, valid stays 0.
//     Stop bit 0 instead -> err_frame pulse.
//  4. Start + 6 data bits, then lines idle for TIMEOUT -> err_frame pulse, FSM IDLE.
//     Next full frame 0x29 -> code=0x29.
//  5. ready=0, FIFO_DEPTH=4, send 0x01..0x05 -> overflow pulse on the 5th.
//     Drain gives 0x01..0x04; pop coinciding with push while full loses nothing.
//  6. 3-cycle low glitch on ps2_clk (FILTER_LEN=8) -> no bit sampled.
//     rst_n low mid-frame -> valid=0, FIFO empty; subsequent frame 0x1C received cleanly.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: sync, deglitch, deframe, check and FIFO scan codes.
// Optional E0/F0 prefix folding into ext/brk flags when PS2_PREFIX_DECODE_EN is defined.
module ps2_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       ext,
    output logic       brk,
    output logic       valid,
    input  logic       ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int TO_LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam int FL_W     = $clog2(FILTER_LEN);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_i_n = rst_sync[1];

    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic            filt;
    logic [FL_W-1:0] fcnt;
    logic            strobe;
    logic            dat_bit;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    // filtered clock only follows the line after FILTER_LEN agreeing samples
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            filt    <= 1'b1;
            fcnt    <= '0;
            strobe  <= 1'b0;
            dat_bit <= 1'b1;
        end else begin
            strobe <= 1'b0;
            if (clk_sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FL_W'(FILTER_LEN - 1)) begin
                filt   <= clk_sync[1];
                fcnt   <= '0;
                strobe <= filt;
                if (filt) dat_bit <= dat_sync[1];
            end else begin
                fcnt <= fcnt + FL_W'(1);
            end
        end
    end

    state_t          state;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TO_W-1:0] tcnt;
    logic            good;
    logic            is_prefix;
    logic            push;
    logic            ext_pend;
    logic            brk_pend;

    always_comb begin
        good = strobe && (state == STOP) && dat_bit && (^{shreg, par_bit});
`ifdef PS2_PREFIX_DECODE_EN
        is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
`else
        is_prefix = 1'b0;
`endif
        push = good && !is_prefix;
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state      <= IDLE;
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            if (strobe) begin
                tcnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!dat_bit) begin
                            state  <= DATA;
                            bitcnt <= 3'd0;
                        end else begin
                            err_frame <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat_bit, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!dat_bit)                  err_frame  <= 1'b1;
                        else if (!(^{shreg, par_bit})) err_parity <= 1'b1;
                    end
                endcase
            end else if (state != IDLE) begin
                if (tcnt == TO_W'(TO_LIMIT)) begin
                    state     <= IDLE;
                    tcnt      <= '0;
                    err_frame <= 1'b1;
                end else begin
                    tcnt <= tcnt + TO_W'(1);
                end
            end
        end
    end

`ifdef PS2_PREFIX_DECODE_EN
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (err_parity || err_frame || push) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (good) begin
            if (shreg == 8'hE0) ext_pend <= 1'b1;
            if (shreg == 8'hF0) brk_pend <= 1'b1;
        end
    end
`else
    assign ext_pend = 1'b0;
    assign brk_pend = 1'b0;
`endif

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             do_write;
    logic [9:0]       head;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = valid && ready;
    assign do_write = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_write, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {ext_pend, brk_pend, shreg};
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);
    assign code  = valid ? head[7:0] : 8'h00;
    assign ext   = valid && head[9];
    assign brk   = valid && head[8];

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: vector table, corner sequences, random frames.
// Expectations follow the default or PS2_PREFIX_DECODE_EN build.
module tb_ps2_rx;

    localparam int K_GOOD = 0;
    localparam int K_PAR  = 1;
    localparam int K_FRM  = 2;

    typedef struct {
        logic [7:0] data;
        bit         flip;
        bit         stop;
        int         kind;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       valid;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    ps2_rx #(
        .CLK_HZ(1_000_000),
        .FILTER_LEN(8),
        .TIMEOUT_US(200),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .code(code),
        .ext(ext),
        .brk(brk),
        .valid(valid),
        .ready(ready),
        .err_parity(err_parity),
        .err_frame(err_frame),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovf = 0;
    logic [9:0] pop_q[$];

    // every accepted head entry is logged as {ext, brk, code}
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_parity) n_par++;
            if (err_frame) n_frm++;
            if (overflow) n_ovf++;
            if (valid && ready) pop_q.push_back({ext, brk, code});
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input bit pulse);
        ps2_dat = b;
        cyc(10);
        ps2_clk = 1'b0;
        if (pulse) begin
            cyc(10);
            ready = 1'b1;
            cyc(1);
            ready = 1'b0;
            cyc(9);
        end else begin
            cyc(20);
        end
        ps2_clk = 1'b1;
        cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                              input int nbits, input bit pulse);
        logic [10:0] bits;
        bits = {stop, ~^d ^ flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], pulse && (i == 10));
        ps2_dat = 1'b1;
        cyc(5);
    endtask

    vec_t       vecs[8];
    int         p0;
    int         f0;
    int         o0;
    bit         stable;
    logic [9:0] exp_q[$];
    bit         ep;
    bit         bp;
    int         epar;
    int         efrm;

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, K_GOOD};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, K_PAR};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, K_FRM};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, K_GOOD};
        vecs[4] = '{8'h00, 1'b0, 1'b1, K_GOOD};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, K_GOOD};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, K_FRM};
        vecs[7] = '{8'h80, 1'b1, 1'b1, K_PAR};

        cyc(5);
        chk("rst_valid", valid, 0);
        chk("rst_code", code, 0);
        chk("rst_extbrk", {ext, brk}, 0);
        chk("rst_errs", {err_parity, err_frame, overflow}, 0);
        rst_n = 1'b1;
        cyc(10);
        chk("post_rst_valid", valid, 0);

        // single frame held while ready is low
        send_frame(8'h1C, 0, 1, 11, 0);
        chk("t1_valid", valid, 1);
        chk("t1_code", code, 8'h1C);
        chk("t1_extbrk", {ext, brk}, 0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (!(valid && code == 8'h1C)) stable = 1'b0;
        end
        chk("t1_held", stable, 1);
        ready = 1'b1;
        cyc(1);
        chk("t1_popped", valid, 0);
        pop_q.delete();

        // vector table, consumer always ready
        for (int i = 0; i < 8; i++) begin
            pop_q.delete();
            p0 = n_par;
            f0 = n_frm;
            send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop, 11, 0);
            cyc(5);
            chk("tbl_par", n_par - p0, vecs[i].kind == K_PAR ? 1 : 0);
            chk("tbl_frm", n_frm - f0, vecs[i].kind == K_FRM ? 1 : 0);
            chk("tbl_pops", pop_q.size(), vecs[i].kind == K_GOOD ? 1 : 0);
            if (pop_q.size() == 1) chk("tbl_code", pop_q[0], {2'b00, vecs[i].data});
        end

        // prefix sequence
        pop_q.delete();
        send_frame(8'hE0, 0, 1, 11, 0);
        send_frame(8'hF0, 0, 1, 11, 0);
        send_frame(8'h74, 0, 1, 11, 0);
        cyc(5);
`ifdef PS2_PREFIX_DECODE_EN
        chk("t2_pops", pop_q.size(), 1);
        if (pop_q.size() == 1) chk("t2_entry", pop_q[0], {2'b11, 8'h74});
`else
        chk("t2_pops", pop_q.size(), 3);
        if (pop_q.size() == 3) begin
            chk("t2_e0", pop_q[0], {2'b00, 8'hE0});
            chk("t2_f0", pop_q[1], {2'b00, 8'hF0});
            chk("t2_74", pop_q[2], {2'b00, 8'h74});
        end
`endif

        // truncated frame times out
        pop_q.delete();
        p0 = n_par;
        f0 = n_frm;
        send_frame(8'h55, 0, 1, 7, 0);
        cyc(300);
        chk("t4_frm", n_frm - f0, 1);
        chk("t4_par", n_par - p0, 0);
        chk("t4_nopop", pop_q.size(), 0);
        send_frame(8'h29, 0, 1, 11, 0);
        cyc(5);
        chk("t4_pops", pop_q.size(), 1);
        if (pop_q.size() == 1) chk("t4_code", pop_q[0], {2'b00, 8'h29});

        // overflow with consumer stalled
        ready = 1'b0;
        cyc(2);
        pop_q.delete();
        o0 = n_ovf;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1, 11, 0);
        chk("t5_no_ovf", n_ovf - o0, 0);
        chk("t5_head", {valid, code}, {1'b1, 8'h01});
        send_frame(8'h05, 0, 1, 11, 0);
        chk("t5_ovf", n_ovf - o0, 1);
        ready = 1'b1;
        cyc(8);
        ready = 1'b0;
        chk("t5_drain_n", pop_q.size(), 4);
        for (int i = 0; i < pop_q.size(); i++)
            chk("t5_drain", pop_q[i], {2'b00, 8'(i + 1)});
        chk("t5_empty", valid, 0);

        // pop coinciding with push while full
        pop_q.delete();
        o0 = n_ovf;
        for (int i = 0; i < 4; i++) send_frame(8'(8'h11 + i), 0, 1, 11, 0);
        send_frame(8'h15, 0, 1, 11, 1);
        chk("t5_simul_ovf", n_ovf - o0, 0);
        ready = 1'b1;
        cyc(8);
        ready = 1'b0;
        chk("t5_simul_n", pop_q.size(), 5);
        for (int i = 0; i < pop_q.size(); i++)
            chk("t5_simul", pop_q[i], {2'b00, 8'(8'h11 + i)});

        // short clock glitch while idle
        f0 = n_frm;
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(40);
        chk("t6_glitch", n_frm - f0, 0);

        // reset mid-frame
        send_frame(8'h33, 0, 1, 11, 0);
        chk("t6_pre_valid", valid, 1);
        send_frame(8'h44, 0, 1, 5, 0);
        rst_n = 1'b0;
        cyc(2);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_code", code, 0);
        rst_n = 1'b1;
        cyc(5);
        chk("t6_after_rst", valid, 0);
        send_frame(8'h1C, 0, 1, 11, 0);
        chk("t6_code", {valid, code}, {1'b1, 8'h1C});
        ready = 1'b1;
        cyc(2);
        chk("t6_single", valid, 0);

        // randomized frames against a reference model
        pop_q.delete();
        p0 = n_par;
        f0 = n_frm;
        ep = 1'b0;
        bp = 1'b0;
        epar = 0;
        efrm = 0;
        for (int i = 0; i < 25; i++) begin
            logic [7:0] d;
            int sel;
            int r;
            sel = $urandom_range(0, 5);
            d = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            r = $urandom_range(0, 9);
            send_frame(d, r == 0, r != 1, 11, 0);
            if (r == 1) begin
                efrm++;
                ep = 0;
                bp = 0;
            end else if (r == 0) begin
                epar++;
                ep = 0;
                bp = 0;
            end else begin
`ifdef PS2_PREFIX_DECODE_EN
                if (d == 8'hE0) ep = 1;
                else if (d == 8'hF0) bp = 1;
                else begin
                    exp_q.push_back({ep, bp, d});
                    ep = 0;
                    bp = 0;
                end
`else
                exp_q.push_back({2'b00, d});
`endif
            end
        end
        cyc(5);
        chk("rnd_par", n_par - p0, epar);
        chk("rnd_frm", n_frm - f0, efrm);
        chk("rnd_pops", pop_q.size(), exp_q.size());
        for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++)
            chk("rnd_entry", pop_q[i], exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
